// File: rtl/ltc2387_pkg.sv
// Shared definitions for the LTC2387 conversion sequencer: FSM states and
// the lower clamps applied to runtime configuration words.
package ltc2387_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_CONV_WAIT,
    S_BURST,
    S_CAPTURE,
    S_WAIT_PERIOD
  } state_t;

  localparam int unsigned MIN_PERIOD   = 2;
  localparam int unsigned MIN_CNV_HIGH = 1;
  localparam int unsigned MIN_BURST    = 1;

  // A sample is in flight from CNV entry until CAPTURE resolves.
  function automatic logic is_busy(input state_t s);
    return s inside {S_CNV, S_CONV_WAIT, S_BURST, S_CAPTURE};
  endfunction

endpackage

// File: rtl/ltc2387_period_timer.sv
// Sample-period down-counter: reloads on reaching zero and flags the boundary
// cycle so the sequencer can start a conversion or log a missed slot.
module ltc2387_period_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] value,
  output logic                 boundary
);

  logic [CNT_WIDTH-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (run) begin
      count <= (count == '0) ? value : count - 1'b1;
    end
  end

  assign boundary = run && (count == '0);

endmodule

// File: rtl/ltc2387_sequencer.sv
// LTC2387 conversion sequencer: CNV pulse, conversion wait, gated DCO burst,
// capture supervision and sticky status for the register map.
module ltc2387_sequencer
  import ltc2387_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] cnv_high,
  input  logic [CNT_WIDTH-1:0] conv_wait,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic                 clear_status,
  input  logic                 adc_valid,
  output logic                 cnv,
  output logic                 clk_gate_en,
  output logic                 capture_start,
  output logic                 sample_tick,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] missed_count
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t TIMEOUT_LOAD = cnt_t'(TIMEOUT - 1);

  function automatic cnt_t clamp_min(input cnt_t v, input int unsigned lo);
    return (v < cnt_t'(lo)) ? cnt_t'(lo) : v;
  endfunction

  state_t state;
  cnt_t   phase_cnt;
  cnt_t   period_lat, conv_wait_lat, burst_lat;
  logic   enable_q;
  logic   boundary, start_seq, timeout_hit, overrun_hit;
  cnt_t   eff_period, eff_cnv_high, eff_burst, timer_value;

  assign eff_period   = clamp_min(period, MIN_PERIOD);
  assign eff_cnv_high = clamp_min(cnv_high, MIN_CNV_HIGH);
  assign eff_burst    = clamp_min(burst_len, MIN_BURST);

  // IDLE reacts to the registered enable so CNV rises two edges after the request.
  assign start_seq   = ((state == S_IDLE) && enable_q) ||
                       ((state == S_WAIT_PERIOD) && boundary && enable);
  assign timeout_hit = (state == S_CAPTURE) && !adc_valid && (phase_cnt == '0);
  assign overrun_hit = boundary && is_busy(state);
  assign timer_value = start_seq ? eff_period - 1'b1 : period_lat - 1'b1;

  ltc2387_period_timer #(.CNT_WIDTH(CNT_WIDTH)) u_period_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state != S_IDLE),
    .load     (start_seq),
    .value    (timer_value),
    .boundary (boundary)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      phase_cnt     <= '0;
      period_lat    <= '0;
      conv_wait_lat <= '0;
      burst_lat     <= '0;
      enable_q      <= 1'b0;
      cnv           <= 1'b0;
      clk_gate_en   <= 1'b0;
      capture_start <= 1'b0;
      sample_tick   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      enable_q      <= enable;
      capture_start <= 1'b0;
      sample_tick   <= 1'b0;
      if (start_seq) begin
        state         <= S_CNV;
        phase_cnt     <= eff_cnv_high - 1'b1;
        period_lat    <= eff_period;
        conv_wait_lat <= conv_wait;
        burst_lat     <= eff_burst;
        cnv           <= 1'b1;
        busy          <= 1'b1;
      end else begin
        case (state)
          S_CNV: begin
            if (phase_cnt != '0) begin
              phase_cnt <= phase_cnt - 1'b1;
            end else begin
              cnv <= 1'b0;
              if (conv_wait_lat == '0) begin
                state         <= S_BURST;
                phase_cnt     <= burst_lat - 1'b1;
                clk_gate_en   <= 1'b1;
                capture_start <= 1'b1;
              end else begin
                state     <= S_CONV_WAIT;
                phase_cnt <= conv_wait_lat - 1'b1;
              end
            end
          end
          S_CONV_WAIT: begin
            if (phase_cnt != '0) begin
              phase_cnt <= phase_cnt - 1'b1;
            end else begin
              state         <= S_BURST;
              phase_cnt     <= burst_lat - 1'b1;
              clk_gate_en   <= 1'b1;
              capture_start <= 1'b1;
            end
          end
          S_BURST: begin
            if (phase_cnt != '0) begin
              phase_cnt <= phase_cnt - 1'b1;
            end else begin
              state       <= S_CAPTURE;
              phase_cnt   <= TIMEOUT_LOAD;
              clk_gate_en <= 1'b0;
            end
          end
          S_CAPTURE: begin
            if (adc_valid) begin
              state       <= S_WAIT_PERIOD;
              sample_tick <= 1'b1;
              busy        <= 1'b0;
            end else if (timeout_hit) begin
              state <= S_WAIT_PERIOD;
              busy  <= 1'b0;
            end else begin
              phase_cnt <= phase_cnt - 1'b1;
            end
          end
          S_WAIT_PERIOD: begin
            if (boundary) state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky status: a set event in the same cycle as clear_status wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      missed_count <= '0;
    end else begin
      if (overrun_hit) begin
        overrun      <= 1'b1;
        missed_count <= clear_status ? cnt_t'(1) :
                        (&missed_count) ? missed_count : missed_count + 1'b1;
      end else if (clear_status) begin
        overrun      <= 1'b0;
        missed_count <= '0;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (clear_status) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ltc2387_sequencer.sv
// Self-checking bench for ltc2387_sequencer: a timeline model (sample start
// time plus elapsed-cycle windows) checked every cycle, plus directed scenarios.
module tb_ltc2387_sequencer;

  localparam int CW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1, enable = 1'b0, clear_status = 1'b0, adc_valid = 1'b0;
  logic [CW-1:0] period = 16'd20, cnv_high = 16'd2, conv_wait = 16'd3, burst_len = 16'd5;
  logic          cnv, clk_gate_en, capture_start, sample_tick, busy, overrun, timeout_err;
  logic [CW-1:0] missed_count;

  ltc2387_sequencer #(.CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .cnv_high(cnv_high),
    .conv_wait(conv_wait), .burst_len(burst_len), .clear_status(clear_status),
    .adc_valid(adc_valid), .cnv(cnv), .clk_gate_en(clk_gate_en),
    .capture_start(capture_start), .sample_tick(sample_tick), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  // ---------------- timeline model ----------------
  // A sample started at edge s occupies: CNV [s, s+H), gate [s+H+W, s+H+W+B),
  // capture from c0 = s+H+W+B until adc_valid or c0+TMO. Boundaries every P.
  int n = 0;
  bit m_run, m_seq, m_enq;
  int s, c0, nb, mh, mw, mb, mp;
  bit e_cnv, e_gate, e_cs, e_tick, e_busy, e_ov, e_to;
  int e_miss;
  bit bnd, busy_b, run_b, tick, set_ov, set_to, start;

  always @(posedge clk) begin
    n++;
    if (rst) begin
      m_run = 0; m_seq = 0; m_enq = 0;
      {e_cnv, e_gate, e_cs, e_tick, e_busy, e_ov, e_to} = '0;
      e_miss = 0;
    end else begin
      run_b  = m_run;
      busy_b = m_seq;
      bnd    = run_b && (n == nb);
      tick   = 0; set_to = 0; start = 0;
      set_ov = bnd && busy_b;
      if (busy_b && n > c0) begin
        if (adc_valid) begin tick = 1; m_seq = 0; end
        else if (n == c0 + TMO) begin set_to = 1; m_seq = 0; end
      end
      if (bnd) begin
        nb = n + mp;
        if (!busy_b) begin
          if (enable) start = 1;
          else m_run = 0;
        end
      end
      if (!run_b && m_enq) start = 1;
      if (start) begin
        mh = eff(int'(cnv_high), 1); mw = int'(conv_wait);
        mb = eff(int'(burst_len), 1); mp = eff(int'(period), 2);
        s = n; c0 = n + mh + mw + mb; nb = n + mp;
        m_seq = 1; m_run = 1;
      end
      m_enq  = enable;
      e_cnv  = m_seq && (n - s < mh);
      e_gate = m_seq && (n - s >= mh + mw) && (n - s < mh + mw + mb);
      e_cs   = m_seq && (n - s == mh + mw);
      e_tick = tick;
      e_busy = m_seq;
      if (set_ov) begin
        e_ov   = 1;
        e_miss = clear_status ? 1 : ((e_miss == 65535) ? e_miss : e_miss + 1);
      end else if (clear_status) begin
        e_ov = 0; e_miss = 0;
      end
      if (set_to) e_to = 1;
      else if (clear_status) e_to = 0;
    end
  end

  // ---------------- compare, monitor, adc_valid source ----------------
  bit   cmp_en = 0;
  int   vmode = 0, vdelay = 2;   // 0: never valid, 1: pulse vdelay after burst end, 2: random
  logic cnv_p, gate_p, to_p;
  int   cnv_rise, gate_rise, gate_fall, to_rise, tick_cnt, cnv_cnt;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cnv",           32'(cnv),           32'(e_cnv));
      check("clk_gate_en",   32'(clk_gate_en),   32'(e_gate));
      check("capture_start", 32'(capture_start), 32'(e_cs));
      check("sample_tick",   32'(sample_tick),   32'(e_tick));
      check("busy",          32'(busy),          32'(e_busy));
      check("overrun",       32'(overrun),       32'(e_ov));
      check("timeout_err",   32'(timeout_err),   32'(e_to));
      check("missed_count",  32'(missed_count),  32'(e_miss));
    end
    if (cnv === 1'b1 && cnv_p !== 1'b1) begin cnv_rise = n; cnv_cnt++; end
    if (clk_gate_en === 1'b1 && gate_p !== 1'b1) gate_rise = n;
    if (clk_gate_en !== 1'b1 && gate_p === 1'b1) gate_fall = n;
    if (timeout_err === 1'b1 && to_p !== 1'b1) to_rise = n;
    if (sample_tick === 1'b1) tick_cnt++;
    cnv_p = cnv; gate_p = clk_gate_en; to_p = timeout_err;
    case (vmode)
      1:       adc_valid = m_seq && (n == c0 + vdelay);
      2:       adc_valid = ($urandom_range(0, 3) == 0);
      default: adc_valid = 1'b0;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_cnv_rise(input int budget, output int at);
    logic p;
    bit found;
    p = cnv; found = 0; at = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (cnv === 1'b1 && p !== 1'b1) begin found = 1; at = n; end
      p = cnv;
    end
    check("wait_cnv_rise_in_budget", 32'(found), 32'd1);
  endtask

  task automatic wait_gate(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (clk_gate_en === 1'b1) found = 1;
    end
    check("wait_gate_in_budget", 32'(found), 32'd1);
  endtask

  task automatic set_cfg(input int p, input int h, input int w, input int b);
    period = CW'(p); cnv_high = CW'(h); conv_wait = CW'(w); burst_len = CW'(b);
  endtask

  task automatic drain_and_clear();
    enable = 0;
    cycles(60);
    clear_status = 1;
    cycles(1);
    clear_status = 0;
    cycles(2);
  endtask

  task automatic randomize_cfg();
    set_cfg($urandom_range(0, 40), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 6));
  endtask

  int n_en, r1, r2, base, rel;

  initial begin
    // Reset state
    cycles(3);
    check("reset_cnv",   32'(cnv), 0);
    check("reset_gate",  32'(clk_gate_en), 0);
    check("reset_busy",  32'(busy), 0);
    check("reset_ovr",   32'(overrun), 0);
    check("reset_tmo",   32'(timeout_err), 0);
    check("reset_miss",  32'(missed_count), 0);
    cmp_en = 1;
    rst = 0;
    cycles(2);

    // Nominal: period 20, cnv 2, wait 3, burst 5, valid 2 cycles after burst
    vmode = 1; vdelay = 2; set_cfg(20, 2, 3, 5);
    base = tick_cnt;
    enable = 1; n_en = n;
    wait_cnv_rise(10, r1);
    check("enable_to_cnv_latency", 32'(r1 - n_en), 32'd2);
    wait_cnv_rise(30, r2);
    check("cnv_spacing_p20", 32'(r2 - r1), 32'd20);
    check("gate_after_cnv", 32'(gate_rise - r1), 32'd5);
    check("gate_len", 32'(gate_fall - gate_rise), 32'd5);
    check("one_tick_per_period", 32'(tick_cnt - base), 32'd1);
    check("no_overrun_p20", 32'(overrun), 32'd0);
    drain_and_clear();

    // Overrun: period 8 -> every other boundary missed, CNV every 16
    set_cfg(8, 2, 3, 5);
    enable = 1;
    wait_cnv_rise(10, r1);
    wait_cnv_rise(30, r2);
    check("cnv_spacing_overrun", 32'(r2 - r1), 32'd16);
    check("burst_not_truncated", 32'(gate_fall - gate_rise), 32'd5);
    check("overrun_set", 32'(overrun), 32'd1);
    // clear_status coincident with the boundary 8 cycles into this sample
    cycles(7);
    clear_status = 1;
    cycles(1);
    clear_status = 0;
    check("clear_vs_set_overrun", 32'(overrun), 32'd1);
    check("clear_vs_set_missed", 32'(missed_count), 32'd1);
    cycles(16);
    check("missed_every_other", 32'(missed_count), 32'd2);
    drain_and_clear();

    // Timeout: adc_valid never arrives
    vmode = 0; set_cfg(40, 2, 3, 5);
    base = tick_cnt;
    enable = 1;
    wait_cnv_rise(10, r1);
    cycles(30);
    check("timeout_latency", 32'(to_rise - gate_fall), 32'd15);
    wait_cnv_rise(30, r2);
    check("cnv_on_boundary_after_tmo", 32'(r2 - r1), 32'd40);
    check("no_tick_on_timeout", 32'(tick_cnt - base), 32'd0);
    drain_and_clear();

    // enable dropped during BURST
    vmode = 1; vdelay = 2; set_cfg(20, 2, 3, 5);
    base = cnv_cnt;
    enable = 1;
    wait_gate(20);
    enable = 0;
    cycles(30);
    check("burst_completes", 32'(gate_fall - gate_rise), 32'd5);
    check("single_cnv_after_drop", 32'(cnv_cnt - base), 32'd1);
    check("idle_not_busy", 32'(busy), 32'd0);
    drain_and_clear();

    // rst mid-CONV_WAIT with sticky flags set, enable held high
    vmode = 0; set_cfg(8, 2, 3, 5);
    enable = 1;
    wait_cnv_rise(10, r1);
    wait_cnv_rise(50, r2);
    check("flags_before_rst", 32'({overrun, timeout_err}), 32'd3);
    cycles(2);
    rst = 1;
    cycles(1);
    rst = 0; rel = n;
    check("rst_cnv", 32'(cnv), 0);
    check("rst_gate", 32'(clk_gate_en), 0);
    check("rst_status", 32'({overrun, timeout_err, busy}), 0);
    check("rst_missed", 32'(missed_count), 0);
    wait_cnv_rise(10, r1);
    check("restart_latency", 32'(r1 - rel), 32'd2);
    drain_and_clear();

    // Randomized traffic against the model
    for (int it = 0; it < 12; it++) begin
      randomize_cfg();
      vmode  = $urandom_range(0, 2);
      vdelay = $urandom_range(0, 16);
      enable = 1;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        rst          = ($urandom_range(0, 99) == 0);
        clear_status = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 15) == 0) enable = ~enable;
        if ($urandom_range(0, 9) == 0) randomize_cfg();
      end
    end
    rst = 0; clear_status = 0;
    drain_and_clear();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ltc2387_sequencer.md
# ltc2387_sequencer

Conversion sequencer for the LTC2387 dual-ADC front end on alpha15. Generates the CNV pulse at a programmable sample period and waits the conversion time. It then opens the gated DCO clock burst that drives the two-lane DDR readout, and hands capture to the `ltc2387` deserializer, whose `adc_valid` it monitors. Runtime configuration and status words are exposed for the register map.

## Interface
- `CNT_WIDTH`, 16, width of all cycle-count config ports and counters
- `TIMEOUT`, 15, cycles allowed in CAPTURE for `adc_valid` before flagging an error
- `clk`  in  1  fabric clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  run request; sampled by the state machine
- `period`  in  CNT_WIDTH  cycles between CNV rising edges; values < 2 treated as 2
- `cnv_high`  in  CNT_WIDTH  CNV high time in cycles; 0 treated as 1
- `conv_wait`  in  CNT_WIDTH  cycles from CNV fall to burst start; 0 allowed
- `burst_len`  in  CNT_WIDTH  clock-gate open cycles; 0 treated as 1
- `clear_status`  in  1  one-cycle pulse; clears sticky status
- `adc_valid`  in  1  word-ready strobe from deserializer
- `cnv`  out  1  ADC conversion-start
- `clk_gate_en`  out  1  enables the gated DCO clock burst
- `capture_start`  out  1  one-cycle pulse to arm deserializer
- `sample_tick`  out  1  one-cycle pulse per completed sample
- `busy`  out  1  high in any state except IDLE and WAIT_PERIOD
- `overrun`  out  1  sticky: period boundary hit while busy
- `timeout_err`  out  1  sticky: CAPTURE timed out
- `missed_count`  out  CNT_WIDTH  saturating count of missed boundaries

## Operation
- States: IDLE, CNV, CONV_WAIT, BURST, CAPTURE, WAIT_PERIOD.
- Reset: state IDLE, all outputs 0, all counters 0.
- Config (`period`, `cnv_high`, `conv_wait`, `burst_len`) is latched on every entry to CNV. Mid-sequence changes take effect at the next CNV.
- IDLE: if `enable`=1, go to CNV next cycle. The period counter loads the effective period minus 1.
- CNV: `cnv`=1 for the effective `cnv_high` cycles, then go to CONV_WAIT. If `conv_wait`=0, go directly to BURST.
- CONV_WAIT: `cnv`=0 for `conv_wait` cycles, then go to BURST.
- BURST: `clk_gate_en`=1 for the effective `burst_len` cycles. `capture_start`=1 on the first BURST cycle only. Then go to CAPTURE.
- CAPTURE: `adc_valid`=1 gives `sample_tick`=1 on the next cycle and goes to WAIT_PERIOD. After `TIMEOUT` cycles without `adc_valid`: set `timeout_err`, go to WAIT_PERIOD, no tick.
- WAIT_PERIOD: when the period counter is 0, go to CNV if `enable`=1, otherwise go to IDLE.
- Period counter:
  - Free-runs down while not IDLE and reloads at 0.
  - A reload while `busy`=1 sets `overrun` and increments `missed_count`, which saturates at all-ones.
  - The sequence completes, then waits for the following boundary. A CNV is never truncated and never doubled.
- `enable` falling mid-sequence: the current sequence finishes, including the full burst, then the block goes to IDLE at WAIT_PERIOD.
- `adc_valid` outside CAPTURE is ignored.
- `clear_status` clears `overrun`, `timeout_err` and `missed_count`. If a set event occurs in the same cycle, the set wins.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `enable` high sampled at edge N in IDLE: `cnv` rises after edge N+1.
- CNV rising edges are exactly the effective `period` cycles apart when no overrun occurs.
- `clk_gate_en` rises `cnv_high` + `conv_wait` cycles after `cnv` rises, in the same cycle as `capture_start`.
- Minimum period without overrun is `cnv_high` + `conv_wait` + `burst_len` + capture latency + 1, where capture latency is the cycles to `adc_valid` + 1.
- `rst` mid-burst: `clk_gate_en` and `cnv` are 0 after that edge; sticky status is cleared.

## Structure
- Shared package `ltc2387_pkg`: state enum, effective-value clamp constants (MIN_PERIOD=2, MIN_CNV_HIGH=1, MIN_BURST=1).
- One sub-module, `ltc2387_period_timer`: down-counter with reload and boundary pulse. The FSM and status registers live in the top level.

## Test plan
- `period`=20, `cnv_high`=2, `conv_wait`=3, `burst_len`=5, `adc_valid` 2 cycles after burst end:
  - `cnv` high 2 cycles every 20 cycles.
  - `clk_gate_en` high 5 cycles starting 5 cycles after `cnv` rises.
  - One `sample_tick` per period; `overrun`=0.
- Same config with `period`=8: `overrun`=1, `missed_count` increments every other boundary, CNV spacing 16 cycles, no truncated burst.
- `adc_valid` never asserted: `timeout_err` set exactly 15 cycles after CAPTURE entry, no `sample_tick`, next CNV still on its boundary.
- `enable` dropped during BURST: burst completes (5 cycles), no further `cnv`, state returns to IDLE, `busy`=0.
- `rst` asserted mid-CONV_WAIT with sticky flags set: next cycle all outputs 0, `missed_count`=0. With `enable` held high, restart produces `cnv` 2 cycles after `rst` release.
- `clear_status` coincident with an overrun boundary: `overrun` remains 1 and `missed_count` = 1.
